// File: rtl/t03_ss_pkg.sv
// Shared types and constants for the seven-segment scanner.
package t03_ss_pkg;

  // Scan FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Segment pattern for a leading-zero-blanked digit.
  localparam logic [7:0] SEG_BLANK  = 8'h00;
  // Segment pattern while no digit is selected (idle or guard time).
  localparam logic [7:0] SEG_ALLOFF = 8'h00;

  // Largest of three integers, used to size the slot counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/t03_ssdec.sv
// Hex nibble to seven-segment decoder (bit 0 = segment a); outputs blank when disabled.
module t03_ssdec
  import t03_ss_pkg::*;
(
  input  logic       en,
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  // Pure lookup; the parent registers the result.
  always_comb begin
    seg = SEG_BLANK;
    if (en) begin
      case (nib)
        4'h0: seg = 8'h3F;
        4'h1: seg = 8'h06;
        4'h2: seg = 8'h5B;
        4'h3: seg = 8'h4F;
        4'h4: seg = 8'h66;
        4'h5: seg = 8'h6D;
        4'h6: seg = 8'h7D;
        4'h7: seg = 8'h07;
        4'h8: seg = 8'h7F;
        4'h9: seg = 8'h6F;
        4'hA: seg = 8'h77;
        4'hB: seg = 8'h7C;
        4'hC: seg = 8'h39;
        4'hD: seg = 8'h5E;
        4'hE: seg = 8'h79;
        4'hF: seg = 8'h71;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/t03_ssscan.sv
// Multiplexed seven-segment display scanner with double-buffered value load.
//
// Load handshake: load_ready is high exactly when the pending buffer is empty.
// A transfer happens on a rising clock edge where load_valid && load_ready;
// load_data is ignored in every other cycle. The pending value becomes visible
// only at a frame end, so a frame is never drawn with a mix of old and new digits.
module t03_ssscan
  import t03_ss_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int DWELL   = 1000,
  parameter int GUARD   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   blank_lz,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NDIGITS-1:0]   load_data,
  output logic [7:0]             seg,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_done,
  output state_t                 dbg_state
);

  localparam int CW = $clog2(max3(DWELL, GUARD, 2));
  localparam int IW = $clog2(NDIGITS);
  localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_M1 = (GUARD > 0) ? CW'(GUARD - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [IW-1:0]          idx, idx_nx, idx_inc;
  logic                   frame_end;
  logic [4*NDIGITS-1:0]   pending, active;
  logic                   pfull;
  logic [3:0]             nib;
  logic                   upper_nz;
  logic                   blanked;
  logic                   dec_en;
  logic [7:0]             dec_seg;
  logic [7:0]             seg_nx;
  logic [NDIGITS-1:0]     an_nx;

  assign load_ready = !pfull;
  assign dbg_state  = state;
  assign idx_inc    = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  // Scan state, slot counter and digit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic; frame_end marks the cycle closing the last digit's slot.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    frame_end = 1'b0;
    if (!enable) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_ON;
          cnt_nx   = DWELL_M1;
          idx_nx   = '0;
        end
        ST_ON: begin
          if (cnt == '0) begin
            if (GUARD == 0) begin
              state_nx  = ST_ON;
              cnt_nx    = DWELL_M1;
              idx_nx    = idx_inc;
              frame_end = (idx == LAST_IDX);
            end else begin
              state_nx = ST_GUARD;
              cnt_nx   = GUARD_M1;
            end
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        ST_GUARD: begin
          if (cnt == '0) begin
            state_nx  = ST_ON;
            cnt_nx    = DWELL_M1;
            idx_nx    = idx_inc;
            frame_end = (idx == LAST_IDX);
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Pending/active buffers: accept a load when empty, swap at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
      pfull   <= 1'b0;
    end else begin
      if (frame_end && pfull) begin
        active <= pending;
        pfull  <= 1'b0;
      end
      if (load_valid && load_ready) begin
        pending <= load_data;
        pfull   <= 1'b1;
      end
    end
  end

  // Select the current nibble and detect whether it and all higher nibbles are zero.
  always_comb begin
    nib      = 4'h0;
    upper_nz = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) nib = active[4*i +: 4];
      if ((IW'(i) >= idx) && (active[4*i +: 4] != 4'h0)) upper_nz = 1'b1;
    end
  end

  assign blanked = blank_lz && (idx != '0) && !upper_nz;
  assign dec_en  = (state == ST_ON) && !blanked;

  t03_ssdec u_dec (
    .en  (dec_en),
    .nib (nib),
    .seg (dec_seg)
  );

  // Output drive; gated by enable so the display goes dark in the same cycle the FSM leaves.
  always_comb begin
    seg_nx = SEG_ALLOFF;
    an_nx  = '0;
    if (enable && (state == ST_ON)) begin
      seg_nx = dec_seg;
      an_nx  = NDIGITS'(1) << idx;
    end
  end

  // Registered outputs: one cycle behind the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_ALLOFF;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nx;
      an         <= an_nx;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_t03_ssscan.sv
// Directed bench for t03_ssscan (NDIGITS=4, DWELL=4, GUARD=2) with an expected-output queue.
module tb_t03_ssscan;
  import t03_ss_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        blank_lz;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  // Expected {frame_done, an, seg} per cycle.
  logic [12:0] exp_q[$];

  logic [7:0] dec_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  t03_ssscan #(.NDIGITS(4), .DWELL(4), .GUARD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // Clock and reset timing
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected outputs of nsamp cycles of a frame showing val.
  // Each digit: 4 cycles lit, 2 cycles dark; frame_done on the 24th cycle.
  task automatic push_frame(input logic [15:0] val, input bit blz, input int nsamp);
    for (int j = 0; j < nsamp; j++) begin
      int         p;
      int         k;
      logic [3:0] nb;
      logic [15:0] upper;
      logic       blk;
      logic [3:0] a;
      logic [7:0] s;
      p     = j % 6;
      k     = (j / 6) % 4;
      upper = val >> (4 * k);
      nb    = upper[3:0];
      blk   = blz && (k != 0) && (upper == 16'h0000);
      a     = (p < 4) ? 4'(1 << k) : 4'h0;
      s     = ((p < 4) && !blk) ? dec_tbl[nb] : 8'h00;
      exp_q.push_back({(j == 23), a, s});
    end
  endtask

  task automatic push_idle();
    exp_q.push_back(13'h0);
  endtask

  // Advance n cycles, comparing DUT outputs against the queue each cycle.
  task automatic check_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scan_queue observed=empty expected=entry");
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("scan", {3'b000, frame_done, an, seg}, {3'b000, e});
      end
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_seg"}, 16'(seg), 16'h00);
    chk({tag, "_an"}, 16'(an), 16'h0);
    chk({tag, "_fd"}, 16'(frame_done), 16'h0);
    chk({tag, "_lr"}, 16'(load_ready), 16'h1);
    chk({tag, "_st"}, 16'(dbg_state), 16'(ST_IDLE));
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    blank_lz   = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    tick();
    tick();
    chk_reset_values("rst0");
    rst = 1'b0;
    tick();

    // Load 0x12AF while idle; then offer junk while not ready.
    load_valid = 1'b1;
    load_data  = 16'h12AF;
    tick();
    chk("lr_after_load", 16'(load_ready), 16'h0);
    load_data = 16'hDEAD;
    tick();
    tick();
    load_valid = 1'b0;
    chk("idle_an", 16'(an), 16'h0);
    chk("idle_st", 16'(dbg_state), 16'(ST_IDLE));

    // Enable: first frame shows zeros, second shows 0x12AF.
    enable = 1'b1;
    push_idle();
    push_frame(16'h0000, 1'b0, 24);
    push_frame(16'h12AF, 1'b0, 24);
    check_cycles(49);
    chk("lr_after_swap", 16'(load_ready), 16'h1);

    // Load A=0x0040, then hold valid with B=0x0007 until it is accepted.
    blank_lz   = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h0040;
    push_frame(16'h12AF, 1'b1, 24);
    check_cycles(1);
    load_data = 16'h0007;
    chk("lr_a_held", 16'(load_ready), 16'h0);
    check_cycles(22);
    chk("lr_before_fe", 16'(load_ready), 16'h0);
    check_cycles(1);
    chk("lr_at_swap", 16'(load_ready), 16'h1);
    push_frame(16'h0040, 1'b1, 24);
    check_cycles(1);
    chk("lr_b_acc", 16'(load_ready), 16'h0);
    load_valid = 1'b0;
    check_cycles(23);

    // Frame showing B; load C exactly on the frame-end cycle.
    push_frame(16'h0007, 1'b1, 24);
    check_cycles(23);
    load_valid = 1'b1;
    load_data  = 16'h3456;
    blank_lz   = 1'b0;
    check_cycles(1);
    load_valid = 1'b0;
    chk("lr_fe_acc", 16'(load_ready), 16'h0);
    push_frame(16'h0007, 1'b0, 24);
    check_cycles(24);

    // C now shown; load D, then drop enable mid-ON of digit 2.
    push_frame(16'h3456, 1'b0, 14);
    load_valid = 1'b1;
    load_data  = 16'h0BCD;
    check_cycles(1);
    load_valid = 1'b0;
    check_cycles(13);
    enable = 1'b0;
    tick();
    chk("dis_an", 16'(an), 16'h0);
    chk("dis_seg", 16'(seg), 16'h00);
    chk("dis_fd", 16'(frame_done), 16'h0);
    chk("dis_st", 16'(dbg_state), 16'(ST_IDLE));
    chk("dis_lr", 16'(load_ready), 16'h0);
    tick();
    tick();
    tick();
    chk("dis_an2", 16'(an), 16'h0);
    chk("dis_fd2", 16'(frame_done), 16'h0);

    // Re-enable: C still active; reset in the middle of a guard interval.
    enable = 1'b1;
    push_idle();
    push_frame(16'h3456, 1'b0, 5);
    check_cycles(6);
    chk("pre_rst_st", 16'(dbg_state), 16'(ST_GUARD));
    rst = 1'b1;
    tick();
    chk_reset_values("rst1");
    rst = 1'b0;

    // After reset both buffers are cleared: a full frame of zeros.
    push_idle();
    push_frame(16'h0000, 1'b0, 24);
    check_cycles(25);
    chk("lr_end", 16'(load_ready), 16'h1);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t03_ssscan.md
T03_SSSCAN -- requirements
Module: t03_ssscan

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DWELL, default 1000, clk cycles each digit is driven (>=2).
REQ-003 SHALL have parameter GUARD, default 16, all-digits-off clk cycles between digits (>=0).
REQ-004 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port enable, input, 1, scan run/stop.
REQ-007 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-008 SHALL have port load_valid, input, 1, new display value offered.
REQ-009 SHALL have port load_ready, output, 1, pending buffer empty; load is accepted.
REQ-010 SHALL have port load_data, input, 4*NDIGITS, hex nibbles; nibble i drives digit i, and digit NDIGITS-1 is most significant.
REQ-011 SHALL have port seg, output, 8, segment pattern of the current digit, bit 0 = segment a.
REQ-012 SHALL have port an, output, NDIGITS, one-hot active-high digit select.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each full scan.

Function
REQ-014 SHALL hold two registers: pending (with flag pfull) and active; the display shows only active.
REQ-015 SHALL drive load_ready = !pfull; a transfer occurs on load_valid && load_ready, and then pending <= load_data and pfull <= 1.
REQ-016 SHALL ignore load_data whenever load_ready = 0.
REQ-017 SHALL use FSM states IDLE, ON, GUARD, with a down-counter cnt and a digit index idx.
REQ-018 IDLE: an=0 and seg=0; when enable=1, SHALL go to ON with idx=0 and cnt=DWELL-1.
REQ-019 ON: cnt decrements each cycle; at cnt=0, SHALL go to GUARD with cnt=GUARD-1, or, if GUARD=0, go directly to the next ON slot.
REQ-020 GUARD: an=0 and seg=0; at cnt=0, SHALL go to ON with idx=idx+1 and cnt=DWELL-1; after idx=NDIGITS-1 it wraps to 0.
REQ-021 SHALL treat the cycle that ends the last slot of digit NDIGITS-1 (GUARD end, or ON end when GUARD=0) as the frame end.
REQ-022 At frame end, SHALL assert frame_done for 1 cycle; if pfull=1, SHALL also copy active <= pending and set pfull <= 0.
REQ-023 If a load is accepted in a frame-end cycle, SHALL not swap the new value in that cycle; the value swaps at the next frame end.
REQ-024 When enable=0 in any state, SHALL go to IDLE on the next cycle with idx=0; no frame_done and no swap occur.
REQ-025 Loads SHALL be accepted in IDLE; a pending value loaded while idle swaps at the first frame end after enable.
REQ-026 In ON, SHALL decode nibble idx of active to a hex seven-segment pattern: 0=0x3F, 1=0x06, ... 8=0x7F, A=0x77, F=0x71.
REQ-027 SHALL blank digit i (seg=0, an bit still set) when blank_lz=1, nibble i=0, and all nibbles above i are 0; digit 0 is never blanked.
REQ-028 SHALL register seg and an, updating them in the cycle after a state/idx change (1-cycle latency).
REQ-029 SHALL keep an one-hot or all-zero at all times, never with two bits set.

Reset
REQ-030 On rst=1, SHALL set state=IDLE, idx=0, cnt=0, pfull=0, active=0, pending=0, seg=0, an=0, frame_done=0, load_ready=1.
REQ-031 rst SHALL take priority over enable and load_valid; a reset mid-scan abandons the frame with no swap.

Structure
REQ-032 The FSM state enum and segment constants for blank and all-off SHALL live in shared package t03_ss_pkg.
REQ-033 SHALL instantiate one t03_ssdec sub-module, time-shared across digits; its enable = (state==ON) && !blanked.
REQ-034 SHALL size cnt to $clog2(max(DWELL,GUARD,2)) bits and idx to $clog2(NDIGITS) bits.

Verification
Use NDIGITS=4, DWELL=4, GUARD=2.
REQ-035 Reset, then enable=1 with active=0 -> an=0001 and seg=0x3F for 4 cycles, then an=0 for 2 cycles, then an=0010.
REQ-036 Load 0x12AF in IDLE, enable -> after 1 frame, frame_done pulse; the next frame shows digits 0..3 as 0x71, 0x77, 0x5B, 0x06.
REQ-037 blank_lz=1, active=0x0040 -> digits 3 and 2 show seg=0, digit 1 shows 0x66, digit 0 shows 0x3F.
REQ-038 Load A accepted, then load_valid held with B -> load_ready=0 until frame end; A is displayed, then B is accepted on a later cycle.
REQ-039 Load accepted exactly on the frame-end cycle -> no swap that frame, swap at the following frame_done.
REQ-040 enable dropped mid-ON of digit 2, and rst asserted mid-GUARD -> both go to IDLE next cycle with an=0 and no frame_done; after rst, all REQ-030 values hold.
